booth_sequencer: RTL and testbench
==================================

BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply.
REQ-005 The block SHALL have port multiplicand, input, N, signed two's-complement M.
REQ-006 The block SHALL have port multiplier, input, N, signed two's-complement Q.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking a valid product.
REQ-009 The block SHALL have port product, output, 2N, signed M*Q.

Function
REQ-010 The block SHALL implement radix-2 sequential Booth multiplication using states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL capture M and Q, clear accumulator A (N+1 bits), clear Q_-1, load count=N, and go to RUN.
REQ-012 In IDLE with start=0, the block SHALL hold all registers.
REQ-013 Each RUN cycle SHALL decode {Q[0],Q_-1}: 01 -> A+M_ext; 10 -> A+~M_ext with CIN=1; 00/11 -> A+0 with CIN=0.
REQ-014 M_ext SHALL be M sign-extended to N+1 bits, so M = -2^(N-1) subtracts without overflow.
REQ-015 Each RUN cycle SHALL register the arithmetic right shift by one of {sum[N:0],Q,Q_-1}, replicating sum[N] into the MSB.
REQ-016 The adder carry-out (bit N+1) SHALL be discarded.
REQ-017 count SHALL decrement each RUN cycle, and RUN SHALL exit to DONE on the cycle count transitions 1->0, which is exactly N RUN cycles.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, product SHALL equal {A[N-1:0],Q}, and the next state SHALL be IDLE.
REQ-019 Latency SHALL be fixed: with start sampled at edge k, done is high during the cycle following edge k+N+1.
REQ-020 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored while busy=1, with no restart and no queuing.
REQ-022 Operands SHALL be sampled only at acceptance; operand input changes during RUN SHALL have no effect.
REQ-023 product SHALL hold its last value until the next DONE and SHALL NOT show intermediate values.
REQ-024 start asserted in the same cycle DONE returns to IDLE SHALL NOT be accepted; it is accepted at the first edge seen in IDLE.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE and clear A, Q, Q_-1, M, count and product to 0, with busy=0 and done=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the partial result SHALL NOT appear on product.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-028 A shared package booth_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default-width constant.
REQ-029 The add/subtract SHALL use one instance of the existing carry_lookahead_adder, with its N parameter set to N+1 and CIN driven from the Booth decode.
REQ-030 The block SHALL contain no other sub-modules and SHALL have exactly one adder instance; the add and subtract paths SHALL NOT be duplicated.

Verification
REQ-031 With N=8, M=3 and Q=5, the bench SHALL check product=0x000F and that done pulses exactly 9 cycles after the start edge.
REQ-032 With M=-128 and Q=-128, the bench SHALL check product=0x4000 (the boundary covered by REQ-014).
REQ-033 With M=-1 and Q=1, the bench SHALL check product=0xFFFF; with M=0 and Q=-77, it SHALL check product=0x0000.
REQ-034 Re-asserting start with new operands at RUN cycle 3 SHALL be ignored, and product SHALL still equal the original M*Q.
REQ-035 Asserting rst_n=0 at RUN cycle 4 SHALL produce busy=0, done=0 and product=0 immediately, and a new start after release SHALL complete correctly.
REQ-036 A random sweep of 1000 signed operand pairs for N=8 and N=4 SHALL match a golden multiply, with exactly one done per accepted start.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and default width for the Booth multiplier
package booth_pkg;

  localparam int BOOTH_DEFAULT_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carry_lookahead_adder.sv
// rtl/carry_lookahead_adder.sv - N-bit carry-lookahead adder with carry-in and carry-out
module carry_lookahead_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         acc;
  logic         pp;

  // Each carry is the flattened OR of generate terms gated by the propagate chain below them.
  always_comb begin
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    acc = 1'b0;
    pp  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
    sum  = p ^ c[N-1:0];
    cout = c[N];
  end

endmodule

// File: rtl/booth_sequencer.sv
// rtl/booth_sequencer.sv - radix-2 sequential Booth multiplier, N RUN cycles per product
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int N = BOOTH_DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  state_e         state_q, state_d;
  logic [N:0]     a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   m_q, m_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  count_q, count_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N:0]     m_ext;
  logic [N:0]     addend;
  logic [N:0]     sum;
  logic           cin;
  logic           cout_unused;

  // Sign-extending M by one bit lets -2^(N-1) be subtracted without overflow.
  always_comb begin
    m_ext  = {m_q[N-1], m_q};
    addend = '0;
    cin    = 1'b0;
    case ({q_q[0], qm1_q})
      2'b01:   addend = m_ext;
      2'b10: begin
        addend = ~m_ext;
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  carry_lookahead_adder #(
    .N(N + 1)
  ) u_adder (
    .a   (a_q),
    .b   (addend),
    .cin (cin),
    .sum (sum),
    .cout(cout_unused)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          count_d = CW'(N);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = {sum[N], sum[N:1]};
        q_d     = {sum[0], q_q[N-1:1]};
        qm1_d   = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d    = 1'b1;
        product_d = {a_q[N-1:0], q_q};
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_sequencer.sv
// tb/tb_booth_sequencer.sv - self-checking bench for booth_sequencer at N=8 and N=4
module tb_booth_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8;
  logic [7:0]  mcand8, mplier8;
  logic        busy8, done8;
  logic [15:0] prod8;
  logic        start4;
  logic [3:0]  mcand4, mplier4;
  logic        busy4, done4;
  logic [7:0]  prod4;

  int checks = 0;
  int errors = 0;

  booth_sequencer #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .multiplicand(mcand8),
    .multiplier(mplier8), .busy(busy8), .done(done8), .product(prod8)
  );

  booth_sequencer #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .multiplicand(mcand4),
    .multiplier(mplier4), .busy(busy4), .done(done4), .product(prod4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 multiply; optionally tries a restart with new operands at RUN cycle 3.
  task automatic mul8(input string tag, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] exp, input logic [15:0] prev, input bit interfere);
    int lat;
    int ndone;
    logic [15:0] got;
    lat = 0;
    ndone = 0;
    got = '0;
    mcand8 = m;
    mplier8 = q;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    for (int e = 1; e <= 14; e++) begin
      if (interfere && e == 3) begin
        start8 = 1'b1;
        mcand8 = 8'h55;
        mplier8 = 8'h22;
      end
      tick();
      if (interfere && e == 3) start8 = 1'b0;
      if (e == 3) check({tag, "_hold"}, 32'(prod8), 32'(prev));
      if (done8) begin
        ndone++;
        lat = e;
        got = prod8;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_ndone"}, 32'(ndone), 32'd1);
    check({tag, "_product"}, 32'(got), 32'(exp));
    check({tag, "_product_held"}, 32'(prod8), 32'(exp));
    check({tag, "_idle"}, 32'(busy8), 32'd0);
  endtask

  int d1, d2, nd;
  int lat8, lat4, cnt8, cnt4, ref8, ref4;
  logic [15:0] got8, exp8;
  logic [7:0]  got4, exp4;
  logic [7:0]  rm8, rq8;
  logic [3:0]  rm4, rq4;

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    mcand8 = '0;
    mplier8 = '0;
    mcand4 = '0;
    mplier4 = '0;
    #12;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_product", 32'(prod8), 32'd0);
    tick();
    rst_n = 1'b1;

    mul8("m3_q5", 8'd3, 8'd5, 16'h000F, 16'h0000, 1'b0);
    mul8("min_min", 8'h80, 8'h80, 16'h4000, 16'h000F, 1'b0);
    mul8("neg1_pos1", 8'hFF, 8'h01, 16'hFFFF, 16'h4000, 1'b0);
    mul8("zero_m77", 8'h00, 8'hB3, 16'h0000, 16'hFFFF, 1'b0);
    mul8("restart_ignored", 8'd7, 8'hF7, 16'hFFC1, 16'h0000, 1'b1);

    // start held high across DONE: the second operation is taken only once back in IDLE
    mcand8 = 8'hFB;
    mplier8 = 8'd6;
    start8 = 1'b1;
    tick();
    d1 = 0;
    d2 = 0;
    nd = 0;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (done8) begin
        nd++;
        if (nd == 1) d1 = e;
        if (nd == 2) d2 = e;
        check("b2b_product", 32'(prod8), 32'h0000FFE2);
      end
    end
    start8 = 1'b0;
    check("b2b_first_done", 32'(d1), 32'd9);
    check("b2b_second_done", 32'(d2), 32'd19);
    check("b2b_ndone", 32'(nd), 32'd2);
    repeat (12) tick();

    // reset at RUN cycle 4 aborts immediately and leaves no trace on product
    mcand8 = 8'd50;
    mplier8 = 8'd3;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_product", 32'(prod8), 32'd0);
    tick();
    rst_n = 1'b1;
    mul8("after_reset", 8'hF6, 8'd12, 16'hFF88, 16'h0000, 1'b0);

    for (int it = 0; it < 1000; it++) begin
      rm8 = 8'($urandom);
      rq8 = 8'($urandom);
      rm4 = 4'($urandom);
      rq4 = 4'($urandom);
      if (it == 0) begin
        rm8 = 8'h80;
        rq8 = 8'h80;
        rm4 = 4'h8;
        rq4 = 4'h8;
      end
      ref8 = $signed(rm8) * $signed(rq8);
      ref4 = $signed(rm4) * $signed(rq4);
      exp8 = ref8[15:0];
      exp4 = ref4[7:0];
      repeat ($urandom_range(0, 2)) tick();
      mcand8 = rm8;
      mplier8 = rq8;
      mcand4 = rm4;
      mplier4 = rq4;
      start8 = 1'b1;
      start4 = 1'b1;
      tick();
      start8 = 1'b0;
      start4 = 1'b0;
      cnt8 = 0;
      cnt4 = 0;
      lat8 = 0;
      lat4 = 0;
      got8 = '0;
      got4 = '0;
      for (int e = 1; e <= 11; e++) begin
        mcand8 = 8'($urandom);
        mplier8 = 8'($urandom);
        mcand4 = 4'($urandom);
        mplier4 = 4'($urandom);
        tick();
        if (done8) begin
          cnt8++;
          lat8 = e;
          got8 = prod8;
        end
        if (done4) begin
          cnt4++;
          lat4 = e;
          got4 = prod4;
        end
      end
      check("rand8_ndone", 32'(cnt8), 32'd1);
      check("rand8_latency", 32'(lat8), 32'd9);
      check("rand8_product", 32'(got8), 32'(exp8));
      check("rand4_ndone", 32'(cnt4), 32'd1);
      check("rand4_latency", 32'(lat4), 32'd5);
      check("rand4_product", 32'(got4), 32'(exp4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
